// File: rtl/stream_mux_rr_if.sv
// Purpose : bundle of the stream mux handshake and data signals (select, inputs, registered output).
// Latency : n/a (wiring only).
// Backpressure: n/a; in_ready/out_ready carry the flow control between the two sides.
//
// Ports (all inside the interface):
//   mode, sel         channel selection controls (driven by the user side)
//   in_valid/in_data  NUM_CH producer streams, channel k at in_data[k*WIDTH +: WIDTH]
//   in_ready          per-channel ready from the mux
//   out_valid/out_data/out_ch  registered output beat and its source channel
//   out_ready         consumer accept
// Modports: master = producers/consumer side, slave = the mux.
interface stream_mux_rr_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*WIDTH-1:0]   in_data;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Purpose : N-channel stream mux, fixed select (mode=0) or round-robin (mode=1), one-entry output register.
// Latency : 1 cycle from the accepting edge to out_valid/out_data/out_ch.
// Backpressure: out_valid && !out_ready holds the output register and drops every in_ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream_mux_rr_if.slave: mode, sel, in_valid, in_data, out_ready in;
//          in_ready (combinational), out_valid, out_data, out_ch (registered) out
module stream_mux_rr #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_rr_if.slave  bus
);
    // Channel vectors are padded up to a power of two so that any sel value,
    // including ones >= NUM_CH, indexes a real bit that reads as "not valid".
    localparam int CH_SLOTS = 1 << SEL_W;

    logic [CH_SLOTS-1:0] valid_ext;
    logic [WIDTH-1:0]    ch_dat [CH_SLOTS];

    // Output register and round-robin pointer.
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]    last_q,      last_d;

    // Arbitration results.
    logic                fix_vld;
    logic                rr_vld;
    logic [SEL_W-1:0]    rr_idx;
    logic [SEL_W-1:0]    cand;
    logic                grant_vld;
    logic [SEL_W-1:0]    grant_idx;
    logic                load;
    logic                take;
    logic [NUM_CH-1:0]   in_ready_vec;

    always_comb begin
        valid_ext               = '0;
        valid_ext[NUM_CH-1:0]   = bus.in_valid;
    end

    for (genvar k = 0; k < CH_SLOTS; k++) begin : g_slot
        if (k < NUM_CH) begin : g_used
            assign ch_dat[k] = bus.in_data[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_dat[k] = '0;
        end
    end

    // Grant selection. Round-robin scans last+1 .. last+NUM_CH (mod NUM_CH),
    // so the channel that won last is considered last again.
    always_comb begin
        fix_vld = valid_ext[bus.sel];
        rr_vld  = 1'b0;
        rr_idx  = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = SEL_W'((int'(last_q) + i) % NUM_CH);
            if (!rr_vld && valid_ext[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
        grant_vld = bus.mode ? rr_vld : fix_vld;
        grant_idx = bus.mode ? rr_idx : bus.sel;
    end

    // The output stage may load whenever it is empty or its beat leaves this cycle.
    assign load = !out_valid_q || bus.out_ready;
    assign take = load && grant_vld;

    always_comb begin
        in_ready_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_ready_vec[k] = take && (grant_idx == SEL_W'(k));
        end
    end

    // Next-state: a load with no grant only drains out_valid; data and channel
    // keep their last values so a consumer peeking at them sees no glitch.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = ch_dat[grant_idx];
                out_ch_d   = grant_idx;
                // Fixed-select transfers leave the pointer alone so that
                // round-robin fairness resumes where it stopped.
                if (bus.mode) begin
                    last_d = grant_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign bus.in_ready  = in_ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Purpose : directed, table-driven check of stream_mux_rr (WIDTH=4, NUM_CH=4).
// Latency : expected outputs in each row are those registered by the previous row's edge.
// Backpressure: rows with out_ready=0 expect a frozen output and in_ready=0000.
module tb_stream_mux_rr;
    logic clk;
    logic rst_n;

    stream_mux_rr_if #(.WIDTH(4), .NUM_CH(4), .SEL_W(2)) mux_if ();

    stream_mux_rr #(.WIDTH(4), .NUM_CH(4), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mux_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [3:0] exp_od;
        logic [1:0] exp_ch;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    int checks;
    int failures;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mode, input logic [1:0] sel, input logic [3:0] vld, input logic ordy);
        mux_if.mode      = mode;
        mux_if.sel       = sel;
        mux_if.in_valid  = vld;
        mux_if.out_ready = ordy;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [3:0] od, input logic [1:0] ch);
        check({tag, ".out_valid"}, 8'(mux_if.out_valid), 8'(ov));
        check({tag, ".out_data"},  8'(mux_if.out_data),  8'(od));
        check({tag, ".out_ch"},    8'(mux_if.out_ch),    8'(ch));
    endtask

    initial begin
        logic [3:0] onehot;
        checks   = 0;
        failures = 0;

        // mode sel vld ordy | in_ready out_valid out_data out_ch
        vecs[0]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b0, 4'h0, 2'd0};
        vecs[1]  = '{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd0};
        vecs[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 4'h2, 2'd1};
        vecs[3]  = '{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd2};
        // round-robin, all valid: pointer still 3 so channel 0 first
        vecs[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h8, 2'd3};
        vecs[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd0};
        vecs[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 4'h2, 2'd1};
        vecs[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd2};
        vecs[8]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h8, 2'd3};
        // sparse: only channels 1 and 3
        vecs[9]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd0};
        vecs[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 4'h2, 2'd1};
        vecs[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 4'h8, 2'd3};
        vecs[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 4'h2, 2'd1};
        // backpressure for 5 cycles
        vecs[13] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[14] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[15] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[16] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[17] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[18] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h8, 2'd3};
        // fixed select of an invalid channel: drain, data holds
        vecs[19] = '{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b1, 4'h1, 2'd0};
        vecs[20] = '{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
        // empty stage loads even with out_ready=0; mode-0 transfer keeps pointer at 0
        vecs[21] = '{1'b0, 2'd2, 4'h4, 1'b0, 4'b0100, 1'b0, 4'h1, 2'd0};
        vecs[22] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd2};
        vecs[23] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h4, 2'd2};
        vecs[24] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 4'h2, 2'd1};
        // single valid channel behind the pointer: wrap-around search
        vecs[25] = '{1'b1, 2'd0, 4'h1, 1'b1, 4'b0001, 1'b0, 4'h2, 2'd1};
        vecs[26] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 4'h1, 2'd0};

        rst_n          = 1'b0;
        mux_if.in_data = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        drive(1'b0, 2'd0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 4'h0, 2'd0);
        check("reset.in_ready", 8'(mux_if.in_ready), 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].mode, vecs[i].sel, vecs[i].vld, vecs[i].ordy);
            @(negedge clk);
            check($sformatf("vec%0d.in_ready", i), 8'(mux_if.in_ready), 8'(vecs[i].exp_rdy));
            check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_ch);
            @(posedge clk);
            #1;
        end

        // Async reset mid-stream. State here: out empty, pointer 0.
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        @(negedge clk);
        check("rst_seq.in_ready0", 8'(mux_if.in_ready), 8'b0010);
        @(posedge clk);
        @(negedge clk);
        check("rst_seq.in_ready1", 8'(mux_if.in_ready), 8'b0100);
        @(posedge clk);
        #1;
        check_out("rst_seq.pre", 1'b1, 4'h4, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_seq.async", 1'b0, 4'h0, 2'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_seq.first_grant", 8'(mux_if.in_ready), 8'b0001);
        @(posedge clk);
        #1;
        check_out("rst_seq.post", 1'b1, 4'h1, 2'd0);

        // Fixed select, 10 cycles per channel, all valid.
        for (int s = 0; s < 4; s++) begin
            onehot = 4'b0001 << s;
            for (int c = 0; c < 10; c++) begin
                drive(1'b0, 2'(s), 4'hF, 1'b1);
                @(negedge clk);
                check($sformatf("fix%0d_%0d.in_ready", s, c), 8'(mux_if.in_ready), 8'(onehot));
                if (c > 0) begin
                    check_out($sformatf("fix%0d_%0d", s, c), 1'b1, onehot, 2'(s));
                end
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Registered N-channel stream multiplexer, the parametrised successor to the team's combinational 4:1 mux. It selects one of NUM_CH valid/ready input streams, either by an explicit select or by fair round-robin, and presents the winner on a one-entry registered output stage with backpressure. It sits between multiple producers and a single shared consumer, for example a shared bus or an output port.

## Interface
- WIDTH, 4: data width per channel, at least 1.
- NUM_CH, 4: number of input channels, at least 2.
- SEL_W, 2: select/channel-index width; must equal clog2(NUM_CH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = fixed select by sel; 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_valid  in  NUM_CH  per-channel valid.
- in_data  in  NUM_CH*WIDTH  flattened data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  out  NUM_CH  per-channel ready, combinational.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered data.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the beat.

## Operation
- Design style: one clock, reset is asynchronous and active-low. No other state exists beyond what is listed here.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
- Load enable: load = !out_valid || out_ready. This is a pass-through pipeline register; full throughput is one beat per cycle.
- Grant, mode=0:
  - grant = sel if sel < NUM_CH and in_valid[sel].
  - Otherwise there is no grant.
  - Other channels are never granted, even if valid.
- Grant, mode=1: the first k with in_valid[k] set, searching last+1, last+2, … modulo NUM_CH, with wrap-around. If no channel is valid, there is no grant.
- in_ready[k] = load && grant valid && grant==k. At most one bit is high, and only if that channel is valid.
- Transfer on channel k: in_valid[k] && in_ready[k] at the clock edge. The output register then takes out_data=in_data[k], out_ch=k, out_valid=1.
- If load=1 with no grant, out_valid goes to 0 at the edge (the consumed beat is drained). out_data and out_ch hold their last values.
- If out_valid=1 && !out_ready, the output register holds all fields unchanged and all in_ready are 0.
- Pointer update: last=k only on a transfer in mode=1. A transfer in mode=0 or an idle cycle leaves last unchanged.
- Mode or sel changes take effect combinationally in the same cycle. The pointer is retained across mode switches.
- Input rules: a producer may not drop in_valid or change in_data while waiting. The mux does not check this. A grant that moves away from a waiting channel when sel changes is permitted.
- Reset asserted mid-operation: outputs go immediately to their reset values and any held beat is discarded.

## Timing
- Latency: 1 cycle from the accepting edge to out_valid/out_data.
- in_ready depends combinationally on in_valid, mode, sel, out_valid, out_ready and the pointer.
- out_* are pure register outputs with no combinational path from inputs.
- Simultaneous events: while out_ready=1, a new beat loads in the same edge the old one is consumed. This sustains back-to-back transfers.

## Test plan
- Fixed select, WIDTH=4, NUM_CH=4:
  - Stimulus: in_data = 0001, 0010, 0100, 1000; all valid; out_ready=1; mode=0; sel=0,1,2,3 for 10 cycles each.
  - Required: out_data follows one cycle later (0001, 0010, 0100, 1000) with out_ch = sel.
- Round-robin fairness:
  - Stimulus: all four channels held valid, out_ready=1, mode=1 after reset.
  - Required: out_ch sequence 0,1,2,3,0,1,…; each channel's in_ready pulses once every 4 cycles.
- Sparse round-robin with wrap:
  - Stimulus: only channels 1 and 3 valid.
  - Required: out_ch alternates 1,3,1,3. Channels 0 and 2 never see in_ready.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with out_valid=1.
  - Required: out_data/out_ch are stable and in_ready=0000 throughout. When out_ready returns to 1, the next round-robin channel loads the same cycle.
- Invalid select and idle:
  - Stimulus: mode=0 with sel=2 and in_valid[2]=0.
  - Required: in_ready=0000; out_valid falls to 0 after the pending beat is consumed; out_data holds its last value.
- Async reset:
  - Stimulus: assert rst_n=0 mid-stream, between clock edges.
  - Required: out_valid, out_data and out_ch go to 0 immediately. After release, the first round-robin grant goes to channel 0.
